// File: rtl/adc_serial_ctrl.sv
// Serial front-end for a 12-bit SPI-style ADC: turns a request into a burst of
// BURST_LEN conversions and presents each result with a one-cycle ready pulse.
module adc_serial_ctrl #(
    parameter int CLK_DIV    = 2,
    parameter int QUIET_CYC  = 4,
    parameter int BURST_LEN  = 8,
    parameter int FRAME_BITS = 16,
    parameter int DATA_W     = 12
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              adc_data_req_i,
    output logic              adc_cs_n_o,
    output logic              adc_sclk_o,
    input  logic              adc_sdata_i,
    output logic [DATA_W-1:0] adc_data_o,
    output logic              adc_data_rdy_o,
    output logic              frame_err_o,
    output logic              busy_o
);

    localparam int CNT_MAX = (CLK_DIV > QUIET_CYC) ? CLK_DIV : QUIET_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = $clog2(FRAME_BITS);

    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(QUIET_CYC - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_BITS - 1);
    localparam logic [7:0]       BURST_END  = 8'(BURST_LEN);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, LATCH, QUIET} state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic [7:0]              burst_q, burst_d;
    logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
    logic                    phase_q, phase_d;
    logic                    cs_n_q, cs_n_d;
    logic                    sclk_q, sclk_d;
    logic [DATA_W-1:0]       data_q, data_d;
    logic                    rdy_q, rdy_d;
    logic                    err_q, err_d;
    logic                    busy_q, busy_d;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            burst_q <= '0;
            shreg_q <= '0;
            phase_q <= 1'b0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b1;
            data_q  <= '0;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            burst_q <= burst_d;
            shreg_q <= shreg_d;
            phase_q <= phase_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            data_q  <= data_d;
            rdy_q   <= rdy_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        burst_d = burst_q;
        shreg_d = shreg_q;
        phase_d = phase_q;
        cs_n_d  = cs_n_q;
        sclk_d  = sclk_q;
        data_d  = data_q;
        rdy_d   = 1'b0;
        err_d   = err_q;
        busy_d  = busy_q;

        case (state_q)
            IDLE: begin
                cs_n_d = 1'b1;
                sclk_d = 1'b1;
                busy_d = 1'b0;
                if (adc_data_req_i) begin
                    state_d = SETUP;
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    burst_d = '0;
                    cnt_d   = '0;
                end
            end
            SETUP: begin
                if (cnt_q == DIV_LAST) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    bit_d   = '0;
                    phase_d = 1'b0;
                    sclk_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SHIFT: begin
                // phase_q: 0 = SCLK low half, 1 = SCLK high half
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (!phase_q) begin
                        sclk_d  = 1'b1;
                        phase_d = 1'b1;
                        shreg_d = {shreg_q[FRAME_BITS-2:0], adc_sdata_i};
                    end else if (bit_q == BIT_LAST) begin
                        state_d = LATCH;
                    end else begin
                        sclk_d  = 1'b0;
                        phase_d = 1'b0;
                        bit_d   = bit_q + BIT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LATCH: begin
                cs_n_d  = 1'b1;
                data_d  = shreg_q[DATA_W-1:0];
                err_d   = |shreg_q[FRAME_BITS-1:DATA_W];
                rdy_d   = 1'b1;
                burst_d = burst_q + 8'd1;
                cnt_d   = '0;
                state_d = QUIET;
            end
            QUIET: begin
                if (cnt_q == QUIET_LAST) begin
                    cnt_d = '0;
                    if (burst_q == BURST_END) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = SETUP;
                        cs_n_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign adc_cs_n_o     = cs_n_q;
    assign adc_sclk_o     = sclk_q;
    assign adc_data_o     = data_q;
    assign adc_data_rdy_o = rdy_q;
    assign frame_err_o    = err_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_adc_serial_ctrl.sv
// Bench for adc_serial_ctrl: default instance against a timing/data reference
// model with a behavioural ADC, plus a fast single-conversion instance.
module tb_adc_serial_ctrl;

    localparam int CD  = 2;
    localparam int FB  = 16;
    localparam int QC  = 4;
    localparam int BL  = 8;
    localparam int RDY_OFS = CD * (2 * FB + 1) + 1;   // 67
    localparam int PER     = RDY_OFS + QC;            // 71
    localparam int BURST   = PER * BL;                // 568

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_a = 1'b0, sdata_a = 1'b0;
    logic        cs_n_a, sclk_a, rdy_a, err_a, busy_a;
    logic [11:0] data_a;
    logic        req_b = 1'b0, sdata_b = 1'b0;
    logic        cs_n_b, sclk_b, rdy_b, err_b, busy_b;
    logic [11:0] data_b;

    adc_serial_ctrl u_dut_a (
        .clk_i(clk), .reset_n_i(reset_n), .adc_data_req_i(req_a),
        .adc_cs_n_o(cs_n_a), .adc_sclk_o(sclk_a), .adc_sdata_i(sdata_a),
        .adc_data_o(data_a), .adc_data_rdy_o(rdy_a), .frame_err_o(err_a),
        .busy_o(busy_a)
    );

    adc_serial_ctrl #(.CLK_DIV(1), .QUIET_CYC(1), .BURST_LEN(1)) u_dut_b (
        .clk_i(clk), .reset_n_i(reset_n), .adc_data_req_i(req_b),
        .adc_cs_n_o(cs_n_b), .adc_sclk_o(sclk_b), .adc_sdata_i(sdata_b),
        .adc_data_o(data_b), .adc_data_rdy_o(rdy_b), .frame_err_o(err_b),
        .busy_o(busy_b)
    );

    // Behavioural ADC for instance A: picks a frame on CS_n fall, shifts it out
    // MSB first, one bit per SCLK falling edge.
    logic [15:0] dir_frames [0:15];
    int          dir_n  = 0;
    int          dir_rd = 0;
    logic [15:0] sent_q [$];
    logic [15:0] frame_a;
    int          ptr_a;

    always @(negedge cs_n_a) begin
        if (dir_rd < dir_n) begin
            frame_a = dir_frames[dir_rd];
            dir_rd++;
        end else begin
            frame_a = 16'($urandom);
            if ($urandom_range(3) != 0) frame_a[15:12] = 4'h0;
        end
        sent_q.push_back(frame_a);
        ptr_a = 15;
    end

    always @(negedge sclk_a) begin
        if (!cs_n_a && ptr_a >= 0) begin
            sdata_a = frame_a[ptr_a];
            ptr_a--;
        end
    end

    logic [15:0] frame_b = 16'h0FFF;
    int          ptr_b;
    always @(negedge cs_n_b) ptr_b = 15;
    always @(negedge sclk_b) begin
        if (!cs_n_b && ptr_b >= 0) begin
            sdata_b = frame_b[ptr_b];
            ptr_b--;
        end
    end

    // Reference model for instance A: burst timing from the conversion
    // period arithmetic, data from the frames the ADC actually sent.
    int          cyc = 0;
    bit          m_busy = 1'b0;
    int          m_start = 0;
    int          m_pop = 0;
    int          m_rdy_total = 0;
    logic        m_rdy = 1'b0, m_err = 1'b0, m_cs = 1'b1, m_sclk = 1'b1;
    logic [11:0] m_data = '0;

    always @(posedge clk) begin
        int d, p, q;
        cyc++;
        if (!reset_n) begin
            m_busy = 1'b0;
            m_rdy  = 1'b0;
            m_data = '0;
            m_err  = 1'b0;
            m_pop  = sent_q.size();
        end else begin
            m_rdy = 1'b0;
            if (m_busy) begin
                d = cyc - m_start;
                if (d == BURST) begin
                    m_busy = 1'b0;
                end else if (d >= RDY_OFS && (d - RDY_OFS) % PER == 0) begin
                    m_rdy = 1'b1;
                    m_rdy_total++;
                    if (m_pop < sent_q.size()) begin
                        m_data = sent_q[m_pop][11:0];
                        m_err  = |sent_q[m_pop][15:12];
                    end else begin
                        m_data = 12'hxxx;
                    end
                    m_pop++;
                end
            end else if (req_a) begin
                m_busy  = 1'b1;
                m_start = cyc;
            end
        end
        m_cs   = 1'b1;
        m_sclk = 1'b1;
        if (m_busy) begin
            p = (cyc - m_start) % PER;
            q = p - CD;
            m_cs = (p < RDY_OFS) ? 1'b0 : 1'b1;
            if (p >= CD && p < CD + 2 * FB * CD) m_sclk = ((q / CD) % 2 == 1);
        end
    end

    int n_chk = 0;
    int n_fail = 0;
    int dut_rdy_total = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (reset_n) begin
            chk("cs_n", 32'(cs_n_a), 32'(m_cs));
            chk("sclk", 32'(sclk_a), 32'(m_sclk));
            chk("busy", 32'(busy_a), 32'(m_busy));
            chk("rdy", 32'(rdy_a), 32'(m_rdy));
            chk("data", 32'(data_a), 32'(m_data));
            chk("frame_err", 32'(err_a), 32'(m_err));
            if (rdy_a) dut_rdy_total++;
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        repeat (2) tick();
        while ((busy_a || m_busy) && n < budget) begin
            tick();
            n++;
        end
        chk("wait_idle_timeout", 32'(busy_a), 32'd0);
        repeat (3) tick();
    endtask

    task automatic pulse_req(input int w);
        req_a = 1'b1;
        repeat (w) tick();
        req_a = 1'b0;
    endtask

    initial begin
        int c0, rises, nrdy, rdy_k, last_k, gmin, gmax;
        logic prev;

        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) tick();
        chk("idle_cs_n", 32'(cs_n_a), 32'd1);
        chk("idle_sclk", 32'(sclk_a), 32'd1);
        chk("idle_rdy", 32'(rdy_a), 32'd0);
        chk("idle_data", 32'(data_a), 32'h000);
        chk("idle_busy", 32'(busy_a), 32'd0);

        // Constant frame 0x0ABC, 8-cycle request pulse
        for (int i = 0; i < 8; i++) dir_frames[dir_n + i] = 16'h0ABC;
        dir_n += 8;
        c0 = dut_rdy_total;
        pulse_req(8);
        wait_idle(1500);
        chk("burst1_pulses", 32'(dut_rdy_total - c0), 32'd8);
        chk("burst1_data", 32'(data_a), 32'hABC);

        // Leading-bit error then clean frame; extra request mid-burst ignored
        dir_frames[dir_n]     = 16'h8123;
        dir_frames[dir_n + 1] = 16'h0456;
        dir_n += 2;
        c0 = dut_rdy_total;
        pulse_req(1);
        repeat (200) tick();
        pulse_req(3);
        wait_idle(1500);
        chk("burst2_pulses", 32'(dut_rdy_total - c0), 32'd8);

        // Request held high: two back-to-back bursts
        c0 = dut_rdy_total;
        req_a = 1'b1;
        repeat (600) tick();
        req_a = 1'b0;
        wait_idle(1500);
        chk("held_req_pulses", 32'(dut_rdy_total - c0), 32'd16);

        // Randomized request widths and ignored re-requests
        for (int r = 0; r < 2; r++) begin
            c0 = dut_rdy_total;
            pulse_req($urandom_range(1, 20));
            repeat ($urandom_range(50, 400)) tick();
            pulse_req($urandom_range(1, 5));
            wait_idle(1500);
            chk("rand_burst_pulses", 32'(dut_rdy_total - c0), 32'd8);
        end

        // Reset in the 9th SCLK period of the 3rd conversion
        c0 = dut_rdy_total;
        req_a = 1'b1;
        tick();
        req_a = 1'b0;
        repeat (2 * PER + CD + 8 * 2 * CD + 1) tick();
        chk("pre_reset_pulses", 32'(dut_rdy_total - c0), 32'd2);
        chk("pre_reset_cs_n", 32'(cs_n_a), 32'd0);
        reset_n = 1'b0;
        #1;
        chk("rst_cs_n", 32'(cs_n_a), 32'd1);
        chk("rst_sclk", 32'(sclk_a), 32'd1);
        chk("rst_rdy", 32'(rdy_a), 32'd0);
        chk("rst_data", 32'(data_a), 32'h000);
        chk("rst_busy", 32'(busy_a), 32'd0);
        repeat (3) tick();
        reset_n = 1'b1;
        c0 = dut_rdy_total;
        repeat (20) tick();
        chk("post_reset_no_rdy", 32'(dut_rdy_total - c0), 32'd0);
        pulse_req(2);
        wait_idle(1500);
        chk("post_reset_pulses", 32'(dut_rdy_total - c0), 32'd8);

        // Fast instance: CLK_DIV=1, QUIET_CYC=1, BURST_LEN=1
        rises = 0; nrdy = 0; rdy_k = -1; last_k = -1; gmin = 999; gmax = 0;
        prev = 1'b1;
        req_b = 1'b1;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (k == 0) begin
                req_b = 1'b0;
                chk("b_busy_start", 32'(busy_b), 32'd1);
            end
            if (!cs_n_b && sclk_b && !prev) begin
                rises++;
                if (last_k >= 0) begin
                    if (k - last_k < gmin) gmin = k - last_k;
                    if (k - last_k > gmax) gmax = k - last_k;
                end
                last_k = k;
            end
            prev = sclk_b;
            if (rdy_b) begin
                nrdy++;
                rdy_k = k;
            end
        end
        chk("b_sclk_rises", 32'(rises), 32'd16);
        chk("b_sclk_period_min", 32'(gmin), 32'd2);
        chk("b_sclk_period_max", 32'(gmax), 32'd2);
        chk("b_rdy_count", 32'(nrdy), 32'd1);
        chk("b_rdy_latency", 32'(rdy_k), 32'd34);
        chk("b_data", 32'(data_b), 32'hFFF);
        chk("b_frame_err", 32'(err_b), 32'd0);
        chk("b_busy_end", 32'(busy_b), 32'd0);
        chk("b_cs_n_end", 32'(cs_n_b), 32'd1);

        chk("rdy_total", 32'(dut_rdy_total), 32'(m_rdy_total));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
